// File: rtl/divide_nr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divide_nr_seq
//  Description : Sequential unsigned fixed-point divider using a linear seed
//                and Newton-Raphson reciprocal refinement on one multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module divide_nr_seq #(
   parameter int W     = 16,
   parameter int FRAC  = 14,
   parameter int ITERS = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] num,
   input  logic [W-1:0] den,
   output logic         busy,
   output logic         done,
   output logic [W:0]   quo,
   output logic         ovf,
   output logic         dz
);

   // Reciprocal kept with c_p fraction bits; two integer bits cover x up to 2
   localparam int c_p  = W + 6;
   localparam int c_mw = c_p + 2;
   localparam int c_lw = $clog2(W);
   localparam int c_sw = $clog2(c_p + W + 1);
   localparam int c_cw = 3;
   localparam logic [c_mw-1:0] c_k48 = c_mw'(((64'd48 << c_p) + 64'd8) / 64'd17);
   localparam logic [c_mw-1:0] c_k32 = c_mw'(((64'd32 << c_p) + 64'd8) / 64'd17);
   localparam logic [c_mw-1:0] c_two = {2'b10, {c_p{1'b0}}};

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      NORM     = 3'd1,
      SEED     = 3'd2,
      ITER_MUL = 3'd3,
      ITER_UPD = 3'd4,
      FINAL    = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [W-1:0]        r_num;
   logic [W-1:0]        r_den;
   logic [c_mw-1:0]     r_dn;
   logic [c_lw-1:0]     r_msb;
   logic [c_mw-1:0]     r_x;
   logic [c_mw-1:0]     r_t;
   logic [c_cw-1:0]     r_cnt;
   logic                r_dz;

   logic [c_lw-1:0]     w_msb;
   logic [c_sw-1:0]     w_nsh;
   logic [c_sw-1:0]     w_fsh;
   logic [c_mw-1:0]     w_dn;
   logic [c_mw-1:0]     w_ma;
   logic [c_mw-1:0]     w_mb;
   logic [2*c_mw-1:0]   w_prod;
   logic [c_mw-1:0]     w_prod_p;
   logic [2*c_mw-1:0]   w_q;
   logic                w_big;
   logic [2*W:0]        w_lhs;
   logic [2*W:0]        w_rhs;
   logic                w_ovf_exact;
   logic                w_accept;

   always_comb begin
      w_msb = '0;
      for (int i = 0; i < W; i++) begin
         if (r_den[i]) w_msb = c_lw'(i);
      end
   end

   assign w_nsh = c_sw'(c_p - 1) - c_sw'(w_msb);
   assign w_dn  = c_mw'(r_den) << w_nsh;
   // Undo normalisation: q = num * x / 2^(c_p + msb + 1 - FRAC)
   assign w_fsh = c_sw'(c_p + 1 - FRAC) + c_sw'(r_msb);

   always_comb begin
      w_ma = r_x;
      w_mb = r_dn;
      case (r_state)
         SEED: begin
            w_ma = c_k32;
            w_mb = r_dn;
         end
         ITER_UPD: begin
            w_ma = r_x;
            w_mb = c_two - r_t;
         end
         FINAL: begin
            w_ma = c_mw'(r_num);
            w_mb = r_x;
         end
         default: ;
      endcase
   end

   assign w_prod   = {{c_mw{1'b0}}, w_ma} * {{c_mw{1'b0}}, w_mb};
   assign w_prod_p = w_prod[c_p +: c_mw];
   assign w_q      = w_prod >> w_fsh;
   assign w_big    = |w_q[2*c_mw-1:W+1];

   // Exact overflow test: num * 2^FRAC >= den * 2^(W+1)
   assign w_lhs       = {{(W+1-FRAC){1'b0}}, r_num, {FRAC{1'b0}}};
   assign w_rhs       = {r_den, {(W+1){1'b0}}};
   assign w_ovf_exact = (w_lhs >= w_rhs);

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (start) w_next = NORM;
         NORM:     w_next = SEED;
         SEED:     w_next = ITER_MUL;
         ITER_MUL: w_next = ITER_UPD;
         ITER_UPD: w_next = (r_cnt == c_cw'(ITERS - 1)) ? FINAL : ITER_MUL;
         FINAL:    w_next = DONE;
         DONE:     w_next = start ? NORM : IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         quo   <= '0;
         ovf   <= 1'b0;
         dz    <= 1'b0;
         r_num <= '0;
         r_den <= '0;
         r_dn  <= '0;
         r_msb <= '0;
         r_x   <= '0;
         r_t   <= '0;
         r_cnt <= '0;
         r_dz  <= 1'b0;
      end else begin
         busy <= (w_next != IDLE) && (w_next != DONE);
         done <= (w_next == DONE);
         if (w_accept) begin
            r_num <= num;
            r_den <= den;
         end
         case (r_state)
            NORM: begin
               r_dn  <= w_dn;
               r_msb <= w_msb;
               r_dz  <= (r_den == '0);
            end
            SEED: begin
               r_x   <= c_k48 - w_prod_p;
               r_cnt <= '0;
            end
            ITER_MUL: r_t <= w_prod_p;
            ITER_UPD: begin
               r_x   <= w_prod_p;
               r_cnt <= r_cnt + c_cw'(1);
            end
            FINAL: begin
               if (r_dz) begin
                  quo <= '1;
                  ovf <= 1'b0;
                  dz  <= 1'b1;
               end else if (w_ovf_exact) begin
                  quo <= '1;
                  ovf <= 1'b1;
                  dz  <= 1'b0;
               end else begin
                  quo <= w_big ? '1 : w_q[W:0];
                  ovf <= 1'b0;
                  dz  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
